chan_selector: RTL and testbench

- Parametrised successor of the team's 2:1 selector: N channels of W bits.
- Uses valid/ready handshakes on every input and on the output, with a registered output stage.
- Two modes: fixed select, where the sel input picks the channel, and round-robin fair arbitration across all valid channels.
- Sits between multiple producers and a single downstream consumer in the datapath.

---
 rtl/chan_selector_pkg.sv | 14 +
 rtl/chan_selector_rr_arbiter.sv | 32 +++
 rtl/chan_selector.sv | 78 +++++++
 tb/tb_chan_selector.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/chan_selector_pkg.sv
// Shared definitions for the N-channel valid/ready selector.
package chan_selector_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  // Index width that never collapses to zero bits for small channel counts.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chan_selector_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter
  import chan_selector_pkg::*;
#(
  parameter  int unsigned NCH  = 4,
  localparam int unsigned SELW = clog2_min1(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [NCH-1:0]  grant,
  output logic [SELW-1:0] gidx,
  output logic            any
);

  logic [SELW-1:0] idx;

  always_comb begin
    grant = '0;
    gidx  = '0;
    any   = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = SELW'((32'(ptr) + k) % NCH);
      if (!any && req[idx]) begin
        grant[idx] = 1'b1;
        gidx       = idx;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/chan_selector.sv
// N-channel selector with fixed or round-robin grant and a registered output stage.
module chan_selector
  import chan_selector_pkg::*;
#(
  parameter  int unsigned NCH  = 4,
  parameter  int unsigned W    = 8,
  localparam int unsigned SELW = clog2_min1(NCH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic [NCH*W-1:0] in_data,
  input  logic [NCH-1:0]  in_valid,
  output logic [NCH-1:0]  in_ready,
  output logic [W-1:0]    out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SELW-1:0] out_ch
);

  logic [SELW-1:0] ptr;
  logic [NCH-1:0]  fix_grant, rr_grant, grant;
  logic [SELW-1:0] rr_idx, gidx;
  logic            rr_any, any, load, is_rr;
  logic [W-1:0]    sel_data;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req   (in_valid),
    .ptr   (ptr),
    .grant (rr_grant),
    .gidx  (rr_idx),
    .any   (rr_any)
  );

  assign is_rr = (mode == MODE_RR);
  assign load  = ~out_valid | out_ready;

  // An out-of-range sel matches no channel, so it yields no grant.
  always_comb begin
    fix_grant = '0;
    for (int unsigned i = 0; i < NCH; i++)
      fix_grant[i] = in_valid[i] && (sel == SELW'(i));
  end

  assign grant    = is_rr ? rr_grant : fix_grant;
  assign any      = is_rr ? rr_any   : |fix_grant;
  assign gidx     = is_rr ? rr_idx   : sel;
  assign in_ready = load ? grant : '0;

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NCH; i++)
      if (grant[i]) sel_data = in_data[i*W +: W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
    end else if (load) begin
      out_valid <= any;
      if (any) begin
        out    <= sel_data;
        out_ch <= gidx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (load && any && is_rr)
      ptr <= (gidx == SELW'(NCH-1)) ? '0 : gidx + 1'b1;
  end

endmodule

// File: tb/tb_chan_selector.sv
// Directed vector bench for chan_selector (NCH=4, W=8).
module tb_chan_selector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_ch;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] v;
    logic       rdy;
    logic [3:0] e_ir;
    logic       e_ov;
    logic [7:0] e_out;
    logic [1:0] e_ch;
  } vec_t;

  vec_t vecs[$];

  chan_selector #(.NCH(4), .W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic m, input logic [1:0] s, input logic [3:0] v, input logic r,
                     input logic [3:0] ir, input logic ov, input logic [7:0] o, input logic [1:0] ch);
    vec_t x;
    x.mode = m; x.sel = s; x.v = v; x.rdy = r;
    x.e_ir = ir; x.e_ov = ov; x.e_out = o; x.e_ch = ch;
    vecs.push_back(x);
  endtask

  task automatic check_out(input string tag, input logic ov, input logic [7:0] o, input logic [1:0] ch);
    check({tag, " out_valid"}, 32'(out_valid), 32'(ov));
    check({tag, " out"},       32'(out),       32'(o));
    check({tag, " out_ch"},    32'(out_ch),    32'(ch));
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = 2'd0;
    in_data   = 32'h44332211;
    in_valid  = 4'b0000;
    out_ready = 1'b0;

    // Fixed sel=2, all valid: steady 0x33 from channel 2.
    add(1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2);
    add(1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2);
    add(1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2);
    // Fixed sel=1 with channel 1 idle: drains and stays empty.
    add(1'b0, 2'd1, 4'b1101, 1'b1, 4'b0000, 1'b0, 8'h33, 2'd2);
    add(1'b0, 2'd1, 4'b1101, 1'b1, 4'b0000, 1'b0, 8'h33, 2'd2);
    // Round-robin, all valid, 8 cycles: 0,1,2,3,0,1,2,3.
    add(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0);
    add(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1);
    add(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2);
    add(1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3);
    add(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0);
    add(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1);
    add(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2);
    add(1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3);
    // Round-robin, 1010 from ptr=0: 1,3,1.
    add(1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1);
    add(1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3);
    add(1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1);
    // Back-pressure 3 cycles holding 0x22, then refill from ptr=2 with no bubble.
    add(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1);
    add(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1);
    add(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1);
    add(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2);
    // Fixed transfer leaves ptr=3 untouched.
    add(1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0);
    add(1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3);
    // Drain without refill, then idle with out_ready low.
    add(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h44, 2'd3);
    add(1'b1, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h44, 2'd3);
    // Empty register loads even with out_ready low; then stalls.
    add(1'b1, 2'd0, 4'b0100, 1'b0, 4'b0100, 1'b1, 8'h33, 2'd2);
    add(1'b1, 2'd0, 4'b0100, 1'b0, 4'b0000, 1'b1, 8'h33, 2'd2);
    // Wrap search from ptr=3 to channel 0.
    add(1'b1, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_out("reset", 1'b0, 8'h00, 2'd0);
    check("reset in_ready", 32'(in_ready), 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      mode      = vecs[i].mode;
      sel       = vecs[i].sel;
      in_valid  = vecs[i].v;
      out_ready = vecs[i].rdy;
      #1;
      check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
      @(posedge clk);
      #1;
      check_out($sformatf("v%0d", i), vecs[i].e_ov, vecs[i].e_out, vecs[i].e_ch);
    end

    // Asynchronous reset while holding a word under back-pressure.
    @(negedge clk);
    mode      = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    #2;
    check("pre-reset out_valid", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    check_out("async reset", 1'b0, 8'h00, 2'd0);
    @(posedge clk);
    #1;
    check_out("in reset", 1'b0, 8'h00, 2'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post-reset in_ready", 32'(in_ready), 32'b0001);
    @(posedge clk);
    #1;
    check_out("post-reset", 1'b1, 8'h11, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
